ram_tdp_be: RTL and testbench

RAM_TDP_BE -- requirements
Module: ram_tdp_be

---
 rtl/ram_tdp_be.sv | 163 ++++++++++++++++
 tb/tb_ram_tdp_be.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_tdp_be.sv
// True dual-port RAM with per-lane byte write enables, one shared clock,
// configurable read pipeline depth and per-port read-during-write behaviour.
module ram_tdp_be #(
  parameter int    DATA_WIDTH   = 32,
  parameter int    BYTE_WIDTH   = 8,
  parameter int    ADDR_WIDTH   = 10,
  parameter int    READ_LATENCY = 1,
  parameter string WRITE_MODE   = "read_first",
  parameter string STYLE        = ""
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en_a,
  input  logic                             en_b,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wr_be_a,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wr_be_b,
  input  logic [ADDR_WIDTH-1:0]            addr_a,
  input  logic [ADDR_WIDTH-1:0]            addr_b,
  input  logic [DATA_WIDTH-1:0]            wr_data_a,
  input  logic [DATA_WIDTH-1:0]            wr_data_b,
  output logic [DATA_WIDTH-1:0]            rd_data_a,
  output logic [DATA_WIDTH-1:0]            rd_data_b,
  output logic                             rd_valid_a,
  output logic                             rd_valid_b,
  output logic                             collision
);

  localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int NP    = 2;

  localparam bit WRITE_FIRST = (WRITE_MODE == "write_first");
  localparam bit NO_CHANGE   = (WRITE_MODE == "no_change");

  if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
    $fatal(1, "ram_tdp_be: DATA_WIDTH must be a multiple of BYTE_WIDTH");
  end
  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
    $fatal(1, "ram_tdp_be: READ_LATENCY must be 1..4");
  end
  if (!(WRITE_MODE == "read_first" || WRITE_MODE == "write_first" ||
        WRITE_MODE == "no_change")) begin : g_bad_mode
    $fatal(1, "ram_tdp_be: unsupported WRITE_MODE");
  end
  if (!(STYLE == "" || STYLE == "block" || STYLE == "ultra" ||
        STYLE == "auto")) begin : g_bad_style
    $fatal(1, "ram_tdp_be: unsupported STYLE");
  end

  typedef logic [DATA_WIDTH-1:0] word_t;
  typedef logic [NB-1:0]         lanes_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;

  (* ram_style = STYLE *) word_t mem [DEPTH];

  // Port 0 is A, port 1 is B; everything below is written once for both.
  logic [NP-1:0] en;
  lanes_t        be    [NP];
  addr_t         addr  [NP];
  word_t         wdata [NP];

  assign en       = {en_b, en_a};
  assign be[0]    = wr_be_a;
  assign be[1]    = wr_be_b;
  assign addr[0]  = addr_a;
  assign addr[1]  = addr_b;
  assign wdata[0] = wr_data_a;
  assign wdata[1] = wr_data_b;

  lanes_t req_lanes [NP];
  lanes_t wr_lanes  [NP];
  logic   same_addr;
  logic   collision_d, collision_q;

  // NOTE: every always_comb output gets a full default before any
  // conditional update, so no path can leave it unassigned (no latch).
  always_comb begin
    same_addr = (addr[0] == addr[1]);
    for (int p = 0; p < NP; p++) begin
      req_lanes[p] = en[p] ? be[p] : '0;
    end
    wr_lanes[0] = req_lanes[0];
    // Port A owns overlapping lanes; B keeps only the lanes A leaves alone.
    wr_lanes[1] = same_addr ? (req_lanes[1] & ~req_lanes[0]) : req_lanes[1];
    collision_d = same_addr && (|(req_lanes[0] & req_lanes[1]));
  end

  // NOTE: the array itself has no reset; contents survive rst and only the
  // write enable is gated by it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int p = 0; p < NP; p++) begin
        for (int i = 0; i < NB; i++) begin
          if (wr_lanes[p][i]) begin
            mem[addr[p]][i*BYTE_WIDTH +: BYTE_WIDTH] <= wdata[p][i*BYTE_WIDTH +: BYTE_WIDTH];
          end
        end
      end
    end
  end

  logic [NP-1:0] rd_req;
  word_t         rd_word [NP];

  // The array read is the pre-edge word, so a port reading what the other
  // port writes always sees the old contents.
  always_comb begin
    for (int p = 0; p < NP; p++) begin
      rd_word[p] = mem[addr[p]];
      rd_req[p]  = en[p] && !(NO_CHANGE && (|req_lanes[p]));
      if (WRITE_FIRST) begin
        for (int i = 0; i < NB; i++) begin
          if (req_lanes[p][i]) begin
            rd_word[p][i*BYTE_WIDTH +: BYTE_WIDTH] = wdata[p][i*BYTE_WIDTH +: BYTE_WIDTH];
          end
        end
      end
    end
  end

  logic [READ_LATENCY-1:0] vld_d [NP];
  logic [READ_LATENCY-1:0] vld_q [NP];
  word_t                   dat_d [NP][READ_LATENCY];
  word_t                   dat_q [NP][READ_LATENCY];

  // Data stages load only behind a valid bit, so rd_data holds between reads.
  always_comb begin
    for (int p = 0; p < NP; p++) begin
      vld_d[p]    = '0;
      vld_d[p][0] = rd_req[p];
      dat_d[p][0] = rd_req[p] ? rd_word[p] : dat_q[p][0];
      for (int s = 1; s < READ_LATENCY; s++) begin
        vld_d[p][s] = vld_q[p][s-1];
        dat_d[p][s] = vld_q[p][s-1] ? dat_q[p][s-1] : dat_q[p][s];
      end
    end
  end

  // NOTE: state registers use non-blocking assignments only, so every flop
  // samples its pre-edge inputs regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int p = 0; p < NP; p++) begin
        vld_q[p] <= '0;
        for (int s = 0; s < READ_LATENCY; s++) begin
          dat_q[p][s] <= '0;
        end
      end
      collision_q <= 1'b0;
    end else begin
      vld_q       <= vld_d;
      dat_q       <= dat_d;
      collision_q <= collision_d;
    end
  end

  assign rd_valid_a = vld_q[0][READ_LATENCY-1];
  assign rd_valid_b = vld_q[1][READ_LATENCY-1];
  assign rd_data_a  = dat_q[0][READ_LATENCY-1];
  assign rd_data_b  = dat_q[1][READ_LATENCY-1];
  assign collision  = collision_q;

endmodule

// File: tb/tb_ram_tdp_be.sv
// Bench for ram_tdp_be: six instances (latency 1..4 read_first, plus
// write_first and no_change at latency 2) share one stimulus stream.
module tb_ram_tdp_be;

  localparam int NI = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en_a, en_b;
  logic [3:0]  be_a, be_b;
  logic [3:0]  addr_a, addr_b;
  logic [31:0] wd_a, wd_b;

  logic [31:0] rdd_a [NI];
  logic [31:0] rdd_b [NI];
  logic        rdv_a [NI];
  logic        rdv_b [NI];
  logic        coll  [NI];

  int n_tests = 0;
  int n_fail  = 0;

  // Instance k: latency and mode (0 read_first, 1 write_first, 2 no_change).
  int lat_of  [NI] = '{1, 2, 3, 4, 2, 2};
  int mode_of [NI] = '{0, 0, 0, 0, 1, 2};

  always #5 clk = ~clk;

  for (genvar k = 0; k < 4; k++) begin : g_lat
    ram_tdp_be #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(4),
                 .READ_LATENCY(k + 1), .WRITE_MODE("read_first")) u_dut (
      .clk(clk), .rst(rst), .en_a(en_a), .en_b(en_b),
      .wr_be_a(be_a), .wr_be_b(be_b), .addr_a(addr_a), .addr_b(addr_b),
      .wr_data_a(wd_a), .wr_data_b(wd_b),
      .rd_data_a(rdd_a[k]), .rd_data_b(rdd_b[k]),
      .rd_valid_a(rdv_a[k]), .rd_valid_b(rdv_b[k]), .collision(coll[k]));
  end

  ram_tdp_be #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(4),
               .READ_LATENCY(2), .WRITE_MODE("write_first")) u_wf (
    .clk(clk), .rst(rst), .en_a(en_a), .en_b(en_b),
    .wr_be_a(be_a), .wr_be_b(be_b), .addr_a(addr_a), .addr_b(addr_b),
    .wr_data_a(wd_a), .wr_data_b(wd_b),
    .rd_data_a(rdd_a[4]), .rd_data_b(rdd_b[4]),
    .rd_valid_a(rdv_a[4]), .rd_valid_b(rdv_b[4]), .collision(coll[4]));

  ram_tdp_be #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(4),
               .READ_LATENCY(2), .WRITE_MODE("no_change")) u_nc (
    .clk(clk), .rst(rst), .en_a(en_a), .en_b(en_b),
    .wr_be_a(be_a), .wr_be_b(be_b), .addr_a(addr_a), .addr_b(addr_b),
    .wr_data_a(wd_a), .wr_data_b(wd_b),
    .rd_data_a(rdd_a[5]), .rd_data_b(rdd_b[5]),
    .rd_valid_a(rdv_a[5]), .rd_valid_b(rdv_b[5]), .collision(coll[5]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int          due;
    logic [31:0] data;
    bit          known;
  } rd_t;

  rd_t         pend    [2*NI][$];
  logic [31:0] last_d  [2*NI];
  bit          last_kn [2*NI];
  logic [31:0] m_mem   [16];
  bit          m_known [16];
  int          cyc      = 0;
  bit          exp_coll = 1'b0;

  function automatic void model_reset();
    for (int i = 0; i < 2*NI; i++) begin
      pend[i].delete();
      last_d[i]  = '0;
      last_kn[i] = 1'b1;
    end
    exp_coll = 1'b0;
  endfunction

  function automatic void sched(input int k, input int p, input logic [3:0] be,
                                input logic [31:0] wd, input logic [31:0] old, input bit kn);
    rd_t e;
    if (mode_of[k] == 2 && be != 4'h0) return;
    e.due   = cyc + lat_of[k] - 1;
    e.data  = old;
    e.known = kn;
    if (mode_of[k] == 1) begin
      for (int i = 0; i < 4; i++) if (be[i]) e.data[8*i +: 8] = wd[8*i +: 8];
      if (be == 4'hF) e.known = 1'b1;
    end
    pend[2*k+p].push_back(e);
  endfunction

  function automatic void apply_write(input logic [3:0] ad, input logic [3:0] be, input logic [31:0] wd);
    for (int i = 0; i < 4; i++) if (be[i]) m_mem[ad][8*i +: 8] = wd[8*i +: 8];
    if (be == 4'hF) m_known[ad] = 1'b1;
  endfunction

  always @(posedge rst) model_reset();

  always @(posedge clk) begin
    logic [31:0] old_a, old_b;
    bit          kn_a, kn_b;
    cyc++;
    if (rst) begin
      model_reset();
    end else begin
      old_a = m_mem[addr_a];
      old_b = m_mem[addr_b];
      kn_a  = m_known[addr_a];
      kn_b  = m_known[addr_b];
      for (int k = 0; k < NI; k++) begin
        if (en_a) sched(k, 0, be_a, wd_a, old_a, kn_a);
        if (en_b) sched(k, 1, be_b, wd_b, old_b, kn_b);
      end
      exp_coll = en_a && en_b && (addr_a == addr_b) && ((be_a & be_b) != 4'h0);
      // B first, then A, so A ends up owning any shared lane.
      if (en_b) apply_write(addr_b, be_b, wd_b);
      if (en_a) apply_write(addr_a, be_a, wd_a);
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      for (int p = 0; p < 2; p++) begin
        int   idx;
        logic exp_v, act_v;
        logic [31:0] act_d;
        rd_t  e;
        idx   = 2*k + p;
        exp_v = 1'b0;
        if (pend[idx].size() > 0 && pend[idx][0].due == cyc) begin
          e = pend[idx].pop_front();
          exp_v        = 1'b1;
          last_d[idx]  = e.data;
          last_kn[idx] = e.known;
        end
        act_v = (p == 1) ? rdv_b[k] : rdv_a[k];
        act_d = (p == 1) ? rdd_b[k] : rdd_a[k];
        check($sformatf("model_i%0d_%s_valid@%0d", k, (p == 1) ? "b" : "a", cyc), act_v, exp_v);
        if (last_kn[idx])
          check($sformatf("model_i%0d_%s_data@%0d", k, (p == 1) ? "b" : "a", cyc), act_d, last_d[idx]);
      end
      check($sformatf("model_i%0d_collision@%0d", k, cyc), coll[k], exp_coll);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic clr();
    en_a = 1'b0; en_b = 1'b0; be_a = '0; be_b = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go();
    step();
    clr();
  endtask

  task automatic drain();
    repeat (6) step();
  endtask

  task automatic acc_a(input logic [3:0] be, input logic [3:0] ad, input logic [31:0] d);
    en_a = 1'b1; be_a = be; addr_a = ad; wd_a = d;
  endtask

  task automatic acc_b(input logic [3:0] be, input logic [3:0] ad, input logic [31:0] d);
    en_b = 1'b1; be_b = be; addr_b = ad; wd_b = d;
  endtask

  task automatic exp_port(input int k, input int p, input logic v, input logic [31:0] d, input string nm);
    check({nm, "_valid"}, (p == 1) ? rdv_b[k] : rdv_a[k], v);
    if (v) check({nm, "_data"}, (p == 1) ? rdd_b[k] : rdd_a[k], d);
  endtask

  function automatic logic [31:0] init_val(input int i);
    case (i)
      2:       return 32'h0102_0304;
      5:       return 32'h1122_3344;
      7:       return 32'h0000_0000;
      default: return 32'h1000_0000 | (i * 32'h0101_0101);
    endcase
  endfunction

  initial begin
    model_reset();
    clr();
    addr_a = '0; addr_b = '0; wd_a = '0; wd_b = '0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      acc_a(4'hF, 4'(i), init_val(i));
      step();
    end
    clr();
    drain();

    // Full write then read back; latency 1 vs 2 boundary.
    acc_a(4'hF, 4'd3, 32'hDEAD_BEEF); go(); drain();
    acc_a(4'h0, 4'd3, 32'h0);         go();
    exp_port(0, 0, 1'b1, 32'hDEAD_BEEF, "rd3_lat1");
    exp_port(1, 0, 1'b0, 32'h0,         "rd3_lat2_early");
    step();
    exp_port(1, 0, 1'b1, 32'hDEAD_BEEF, "rd3_lat2");
    drain();

    // Partial write: old word, merged word, or nothing, depending on mode.
    acc_a(4'b0101, 4'd5, 32'hAABB_CCDD); go();
    exp_port(0, 0, 1'b1, 32'h1122_3344, "pw_rf_lat1");
    step();
    exp_port(1, 0, 1'b1, 32'h1122_3344, "pw_rf_lat2");
    exp_port(4, 0, 1'b1, 32'h11BB_33DD, "pw_wf");
    exp_port(5, 0, 1'b0, 32'h0,         "pw_nc");
    step(); step();
    exp_port(3, 0, 1'b1, 32'h1122_3344, "pw_rf_lat4");
    drain();
    acc_a(4'h0, 4'd5, 32'h0); go(); step();
    exp_port(1, 0, 1'b1, 32'h11BB_33DD, "pw_readback_rf");
    exp_port(5, 0, 1'b1, 32'h11BB_33DD, "pw_readback_nc");
    drain();

    // Dual write with overlapping lane 1.
    acc_a(4'b0011, 4'd7, 32'h0000_00AA);
    acc_b(4'b0110, 4'd7, 32'hBBBB_BBBB);
    go();
    check("coll_pulse", coll[1], 1'b1);
    step();
    check("coll_clear", coll[1], 1'b0);
    drain();
    acc_a(4'h0, 4'd7, 32'h0); go(); step();
    exp_port(1, 0, 1'b1, 32'h00BB_00AA, "coll_merge");
    drain();

    // B reads what A writes in the same cycle.
    acc_a(4'hF, 4'd2, 32'hCAFE_F00D);
    acc_b(4'h0, 4'd2, 32'h0);
    go(); step();
    exp_port(1, 1, 1'b1, 32'h0102_0304, "rw_cross_rf");
    exp_port(4, 1, 1'b1, 32'h0102_0304, "rw_cross_wf");
    drain();
    acc_b(4'h0, 4'd2, 32'h0); go(); step();
    exp_port(1, 1, 1'b1, 32'hCAFE_F00D, "rw_cross_after");
    drain();

    // Reset in the middle of a read burst; a write during reset is dropped.
    acc_a(4'h0, 4'd0, 32'h0); step();
    acc_a(4'h0, 4'd1, 32'h0); step();
    acc_a(4'h0, 4'd2, 32'h0); step();
    exp_port(1, 0, 1'b1, 32'h1101_0101, "burst_before_rst");
    acc_a(4'h0, 4'd3, 32'h0);
    acc_b(4'hF, 4'd0, 32'hFFFF_FFFF);
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < NI; k++) begin
      check($sformatf("rst_valid_i%0d", k), rdv_a[k], 1'b0);
      check($sformatf("rst_data_i%0d", k),  rdd_a[k], 32'h0);
      check($sformatf("rst_coll_i%0d", k),  coll[k],  1'b0);
    end
    step();
    #3 rst = 1'b0;
    clr();
    repeat (6) begin
      step();
      for (int k = 0; k < NI; k++) check($sformatf("no_stale_i%0d", k), rdv_a[k], 1'b0);
    end
    acc_a(4'h0, 4'd0, 32'h0);
    acc_b(4'h0, 4'd1, 32'h0);
    go(); step();
    exp_port(1, 0, 1'b1, 32'h1000_0000, "mem_kept_a0");
    exp_port(1, 1, 1'b1, 32'h1101_0101, "mem_kept_a1");
    drain();

    // Random dual-port traffic, checked every cycle by the model.
    repeat (300) begin
      en_a   = 1'($urandom_range(0, 1));
      en_b   = 1'($urandom_range(0, 1));
      be_a   = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom);
      be_b   = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom);
      addr_a = 4'($urandom);
      addr_b = ($urandom_range(0, 2) == 0) ? addr_a : 4'($urandom);
      wd_a   = $urandom;
      wd_b   = $urandom;
      step();
    end
    clr();
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
